// File: rtl/fft_r22sdf_twiddle.sv
// Twiddle multiply stage of a radix-2^2 SDF FFT: z = x * W(e) with a fixed 4-cycle latency.
// Trivial twiddles (e == 0) bypass the multiplier so those samples pass bit-exact.
module fft_r22sdf_twiddle #(
  parameter int unsigned DW        = 24,
  parameter int unsigned TWW       = 25,
  parameter int unsigned FFT_N     = 1024,
  parameter int unsigned FFT_NLOG2 = 10,
  parameter int unsigned STAGE     = 0,
  parameter string       TW_FILE   = "twiddle_s0.hex"
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  input  logic [FFT_NLOG2-1:0] cnt_i,
  input  logic [DW-1:0]        x_re_i,
  input  logic [DW-1:0]        x_im_i,
  output logic                 valid_o,
  output logic [FFT_NLOG2-1:0] cnt_o,
  output logic [DW-1:0]        z_re_o,
  output logic [DW-1:0]        z_im_o
);

  localparam int unsigned L     = FFT_NLOG2 - 2 * STAGE;
  localparam int unsigned DEPTH = 3 * (1 << (L - 2));
  localparam int unsigned PW    = DW + TWW;
  localparam int unsigned SW    = PW + 1;
  localparam real         PI    = 3.14159265358979323846;

  localparam logic signed [SW-1:0] RND  = SW'(64'sd1 <<< (TWW - 2));
  localparam logic signed [SW-1:0] SMAX = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(64'sd1 <<< (DW - 1)));

  // TW_FILE names the image holding these same coefficients; the ROM below is built from the formula.
  if (STAGE > FFT_NLOG2 / 2 - 2 || FFT_N != (1 << FFT_NLOG2) || TW_FILE == "") begin : g_bad_cfg
    $error("fft_r22sdf_twiddle: illegal STAGE / FFT_N / TW_FILE configuration");
  end

  function automatic int rnd_int(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // {c, s} for entry e, evaluated at elaboration by a Taylor series of cos/sin.
  function automatic logic [2*TWW-1:0] tw_word(input int unsigned e);
    real th, cs, sn, term, span, m;
    int  ci, si;
    span = 1.0;
    for (int i = 0; i < int'(L); i++) span = span * 2.0;
    m = 1.0;
    for (int i = 0; i < int'(TWW) - 1; i++) m = m * 2.0;
    m    = m - 1.0;
    th   = 2.0 * PI * $itor(e) / span;
    cs   = 1.0;
    sn   = 0.0;
    term = 1.0;
    for (int n = 1; n <= 40; n++) begin
      term = term * th / $itor(n);
      case (n % 4)
        1:       sn = sn + term;
        2:       cs = cs - term;
        3:       sn = sn - term;
        default: cs = cs + term;
      endcase
    end
    ci = rnd_int(cs * m);
    si = rnd_int(sn * m);
    return {TWW'(ci), TWW'(si)};
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX) return DW'(SMAX);
    if (v < SMIN) return DW'(SMIN);
    return DW'(v);
  endfunction

  logic [2*TWW-1:0] rom_w [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [2*TWW-1:0] WORD = tw_word(gi);
    assign rom_w[gi] = WORD;
  end

  logic [L-1:0]            e_d, e_q;
  logic                    byp1_d, byp1_q, byp2_q, byp3_q;
  logic                    v1_q, v2_q, v3_q, valid_q;
  logic [FFT_NLOG2-1:0]    cnt1_q, cnt2_q, cnt3_q, cnt_q;
  logic signed [DW-1:0]    xr1_q, xi1_q, xr2_q, xi2_q, xr3_q, xi3_q;
  logic [2*TWW-1:0]        tw_q;
  logic signed [TWW-1:0]   c2, s2;
  logic signed [PW-1:0]    p_rc_d, p_is_d, p_ic_d, p_rs_d;
  logic signed [PW-1:0]    p_rc_q, p_is_q, p_ic_q, p_rs_q;
  logic signed [SW-1:0]    s_re, s_im, sh_re, sh_im;
  logic signed [DW-1:0]    z_re_d, z_im_d, z_re_q, z_im_q;

  // e = r * (2*b0 + b1) from the local index; products; round, saturate, bypass select.
  always_comb begin
    e_d    = L'(cnt_i[L-3:0]) * L'({cnt_i[L-2], cnt_i[L-1]});
    byp1_d = (e_d == '0);
    c2     = $signed(tw_q[2*TWW-1:TWW]);
    s2     = $signed(tw_q[TWW-1:0]);
    p_rc_d = PW'(xr2_q) * PW'(c2);
    p_is_d = PW'(xi2_q) * PW'(s2);
    p_ic_d = PW'(xi2_q) * PW'(c2);
    p_rs_d = PW'(xr2_q) * PW'(s2);
    s_re   = SW'(p_rc_q) + SW'(p_is_q) + RND;
    s_im   = SW'(p_ic_q) - SW'(p_rs_q) + RND;
    sh_re  = s_re >>> (TWW - 1);
    sh_im  = s_im >>> (TWW - 1);
    z_re_d = byp3_q ? xr3_q : sat(sh_re);
    z_im_d = byp3_q ? xi3_q : sat(sh_im);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      e_q     <= '0;
      byp1_q  <= 1'b0;
      byp2_q  <= 1'b0;
      byp3_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      valid_q <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      cnt3_q  <= '0;
      cnt_q   <= '0;
      xr1_q   <= '0;
      xi1_q   <= '0;
      xr2_q   <= '0;
      xi2_q   <= '0;
      xr3_q   <= '0;
      xi3_q   <= '0;
      tw_q    <= '0;
      p_rc_q  <= '0;
      p_is_q  <= '0;
      p_ic_q  <= '0;
      p_rs_q  <= '0;
      z_re_q  <= '0;
      z_im_q  <= '0;
    end else begin
      // P1
      e_q     <= e_d;
      byp1_q  <= byp1_d;
      v1_q    <= valid_i;
      cnt1_q  <= cnt_i;
      xr1_q   <= $signed(x_re_i);
      xi1_q   <= $signed(x_im_i);
      // P2
      tw_q    <= rom_w[e_q];
      byp2_q  <= byp1_q;
      v2_q    <= v1_q;
      cnt2_q  <= cnt1_q;
      xr2_q   <= xr1_q;
      xi2_q   <= xi1_q;
      // P3
      p_rc_q  <= p_rc_d;
      p_is_q  <= p_is_d;
      p_ic_q  <= p_ic_d;
      p_rs_q  <= p_rs_d;
      byp3_q  <= byp2_q;
      v3_q    <= v2_q;
      cnt3_q  <= cnt2_q;
      xr3_q   <= xr2_q;
      xi3_q   <= xi2_q;
      // P4
      z_re_q  <= z_re_d;
      z_im_q  <= z_im_d;
      valid_q <= v3_q;
      cnt_q   <= cnt3_q;
    end
  end

  assign valid_o = valid_q;
  assign cnt_o   = cnt_q;
  assign z_re_o  = z_re_q;
  assign z_im_o  = z_im_q;

endmodule

// File: tb/tb_fft_r22sdf_twiddle.sv
// Directed vector tables on a 16-point instance plus a randomized 3-frame run on a 1024-point instance.
module tb_fft_r22sdf_twiddle;

  localparam int unsigned DW  = 24;
  localparam int unsigned TWW = 25;

  typedef struct {
    logic       v;
    logic [3:0] cnt;
    int         xr;
    int         xi;
    int         er;
    int         ei;
    int         tol;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid_i = 1'b0, a_valid_o;
  logic [3:0]  a_cnt_i = '0, a_cnt_o;
  logic [DW-1:0] a_xr_i = '0, a_xi_i = '0, a_zr_o, a_zi_o;
  logic        b_valid_i = 1'b0, b_valid_o;
  logic [9:0]  b_cnt_i = '0, b_cnt_o;
  logic [DW-1:0] b_xr_i = '0, b_xi_i = '0, b_zr_o, b_zi_o;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t q[$];
  string grp;
  int hr[3072];
  int hi[3072];

  always #5 clk = ~clk;

  fft_r22sdf_twiddle #(.DW(DW), .TWW(TWW), .FFT_N(16), .FFT_NLOG2(4), .STAGE(0)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(a_valid_i), .cnt_i(a_cnt_i),
    .x_re_i(a_xr_i), .x_im_i(a_xi_i), .valid_o(a_valid_o), .cnt_o(a_cnt_o),
    .z_re_o(a_zr_o), .z_im_o(a_zi_o)
  );

  fft_r22sdf_twiddle #(.DW(DW), .TWW(TWW), .FFT_N(1024), .FFT_NLOG2(10), .STAGE(0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(b_valid_i), .cnt_i(b_cnt_i),
    .x_re_i(b_xr_i), .x_im_i(b_xi_i), .valid_o(b_valid_o), .cnt_o(b_cnt_o),
    .z_re_o(b_zr_o), .z_im_o(b_zi_o)
  );

  task automatic chk(input string nm, input longint act, input longint exp, input int tol);
    longint d;
    n_tests++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  function automatic void add(input logic v, input int cnt, input int xr, input int xi,
                              input int er, input int ei, input int tol);
    vec_t e;
    e.v = v; e.cnt = 4'(cnt); e.xr = xr; e.xi = xi; e.er = er; e.ei = ei; e.tol = tol;
    q.push_back(e);
  endfunction

  // Stream the queued vectors back to back; each result is due 4 edges after it is presented.
  task automatic run_q();
    int n;
    n = q.size();
    for (int t = 0; t < n + 4; t++) begin
      @(posedge clk); #1;
      if (t >= 4) begin
        vec_t e;
        e = q[t-4];
        chk($sformatf("%s[%0d] valid", grp, t-4), longint'(a_valid_o), longint'(e.v), 0);
        chk($sformatf("%s[%0d] cnt", grp, t-4), longint'(a_cnt_o), longint'(e.cnt), 0);
        if (e.v) begin
          chk($sformatf("%s[%0d] re", grp, t-4), longint'($signed(a_zr_o)), longint'(e.er), e.tol);
          chk($sformatf("%s[%0d] im", grp, t-4), longint'($signed(a_zi_o)), longint'(e.ei), e.tol);
        end
      end
      if (t < n) begin
        a_valid_i = q[t].v;
        a_cnt_i   = q[t].cnt;
        a_xr_i    = DW'(q[t].xr);
        a_xi_i    = DW'(q[t].xi);
      end else begin
        a_valid_i = 1'b0;
      end
    end
    q.delete();
  endtask

  function automatic int rsat(input real v);
    real f;
    f = $floor(v + 0.5);
    if (f > 8388607.0) return 8388607;
    if (f < -8388608.0) return -8388608;
    return $rtoi(f);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", longint'(a_valid_o), 0, 0);
    chk("reset cnt", longint'(a_cnt_o), 0, 0);
    chk("reset re", longint'($signed(a_zr_o)), 0, 0);
    chk("reset im", longint'($signed(a_zi_o)), 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed twiddle table at N=16 (passthrough, quarter turn, saturation, wrap)
    grp = "tbl";
    add(1, 0, 123, -456, 123, -456, 0);
    add(1, 1, 123, -456, 123, -456, 0);
    add(1, 2, -8388608, 8388607, -8388608, 8388607, 0);
    add(1, 3, 123, -456, 123, -456, 0);
    add(1, 4, 777, -1, 777, -1, 0);
    add(1, 5, 8388607, 8388607, 8388607, 0, 1);
    add(1, 6, 1000, 0, 0, -1000, 0);
    add(1, 7, -8388608, 0, 5931642, 5931642, 1);
    add(1, 8, 5, -5, 5, -5, 0);
    add(1, 9, 1000, 0, 924, -383, 1);
    add(1, 10, 0, 1000, 707, 707, 1);
    add(1, 11, 1000, 0, 383, -924, 1);
    add(1, 12, -8388608, -8388608, -8388608, -8388608, 0);
    add(1, 13, 0, -1000, -924, -383, 1);
    add(1, 14, 1000, 1000, 0, -1414, 1);
    add(1, 15, 1000, 0, -924, 383, 1);
    add(1, 0, 1, 2, 1, 2, 0);
    add(1, 5, -8388608, -8388608, -8388608, 0, 1);
    add(0, 6, 1000, 0, 0, 0, 0);
    add(1, 6, 0, -8388608, -8388607, 0, 1);
    run_q();

    // valid_i gap pattern 1101_0011
    grp = "gap";
    add(1, 0, 100, -100, 100, -100, 0);
    add(1, 1, 101, -101, 101, -101, 0);
    add(0, 2, 102, -102, 102, -102, 0);
    add(1, 3, 103, -103, 103, -103, 0);
    add(0, 4, 104, -104, 104, -104, 0);
    add(0, 8, 105, -105, 105, -105, 0);
    add(1, 12, 106, -106, 106, -106, 0);
    add(1, 0, 107, -107, 107, -107, 0);
    run_q();

    // Mid-stream reset for 2 cycles, release together with a fresh valid sample
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a_valid_i = 1'b1;
      a_cnt_i   = 4'(i % 4);
      a_xr_i    = DW'(i + 1);
      a_xi_i    = DW'(-(i + 1));
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst valid", longint'(a_valid_o), 0, 0);
    chk("rst cnt", longint'(a_cnt_o), 0, 0);
    chk("rst re", longint'($signed(a_zr_o)), 0, 0);
    chk("rst im", longint'($signed(a_zi_o)), 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst hold%0d valid", i), longint'(a_valid_o), 0, 0);
    end
    rst_n     = 1'b1;
    a_valid_i = 1'b1;
    a_cnt_i   = 4'd0;
    a_xr_i    = DW'(321);
    a_xi_i    = DW'(-654);
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1;
      if (t < 4) begin
        chk($sformatf("post-rst %0d valid", t), longint'(a_valid_o), 0, 0);
      end else begin
        chk("post-rst first valid", longint'(a_valid_o), 1, 0);
        chk("post-rst first cnt", longint'(a_cnt_o), 0, 0);
        chk("post-rst first re", longint'($signed(a_zr_o)), 321, 0);
        chk("post-rst first im", longint'($signed(a_zi_o)), -654, 0);
      end
      a_cnt_i = 4'(t);
      a_xr_i  = DW'(321 + t);
      a_xi_i  = DW'(-654 - t);
    end
    @(posedge clk); #1;
    a_valid_i = 1'b0;

    // Three back-to-back 1024-point frames against a floating-point model
    for (int t = 0; t < 3072 + 4; t++) begin
      @(posedge clk); #1;
      if (t >= 4) begin
        int k, e, er, ei;
        real th, c, s;
        k = (t - 4) % 1024;
        e = (k & 255) * (2 * ((k >> 8) & 1) + ((k >> 9) & 1));
        if (e == 0) begin
          er = hr[t-4];
          ei = hi[t-4];
        end else begin
          th = 2.0 * 3.14159265358979323846 * $itor(e) / 1024.0;
          c  = $cos(th);
          s  = $sin(th);
          er = rsat($itor(hr[t-4]) * c + $itor(hi[t-4]) * s);
          ei = rsat($itor(hi[t-4]) * c - $itor(hr[t-4]) * s);
        end
        chk($sformatf("frame[%0d] valid", t-4), longint'(b_valid_o), 1, 0);
        chk($sformatf("frame[%0d] cnt", t-4), longint'(b_cnt_o), longint'(k), 0);
        chk($sformatf("frame[%0d] re", t-4), longint'($signed(b_zr_o)), longint'(er), 1);
        chk($sformatf("frame[%0d] im", t-4), longint'($signed(b_zi_o)), longint'(ei), 1);
      end
      if (t < 3072) begin
        hr[t] = int'($urandom_range(0, 8388607)) - 4194304;
        hi[t] = int'($urandom_range(0, 8388607)) - 4194304;
        b_valid_i = 1'b1;
        b_cnt_i   = 10'(t % 1024);
        b_xr_i    = DW'(hr[t]);
        b_xi_i    = DW'(hi[t]);
      end else begin
        b_valid_i = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_r22sdf_twiddle.md
# fft_r22sdf_twiddle

Twiddle-factor multiply stage of the radix-2² single-delay-feedback FFT pipeline. It sits directly downstream of each butterfly pair (BFI+BFII), except after the final one. It multiplies every complex sample by the twiddle W selected from the incoming sample counter, and forwards a latency-matched counter to the next butterfly pair. The block is fully pipelined at one sample per clock, with a fixed latency of 4 cycles.

## Interface
- `DW`, 24: signed width of each real/imag data component, in and out.
- `TWW`, 25: signed width of twiddle coefficients, including sign.
- `FFT_N`, 1024: transform length.
- `FFT_NLOG2`, 10: log2(FFT_N).
- `STAGE`, 0: index of the butterfly pair feeding this block. Legal range: 0 ≤ STAGE ≤ FFT_NLOG2/2 − 2.
- `TW_FILE`, "twiddle_s0.hex": $readmemh image of the coefficient ROM, one {cos,sin} word per line.

Ports:
- `clk_i` in 1: clock. All state is on the rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: input sample qualifier.
- `cnt_i` in FFT_NLOG2: sample counter accompanying `x_*_i` (the butterfly's `cnt_o`).
- `x_re_i`, `x_im_i` in DW: signed input sample.
- `valid_o` out 1: output qualifier.
- `cnt_o` out FFT_NLOG2: `cnt_i` delayed 4 cycles.
- `z_re_o`, `z_im_o` out DW: signed product x·W.

## Operation
- Local index width: L = FFT_NLOG2 − 2·STAGE.
- Index fields: k = cnt_i[L−1:0]; b1 = k[L−1]; b0 = k[L−2]; r = k[L−3:0].
- Exponent: e = r·(2·b0 + b1), range 0 … 3·(2^(L−2)−1). The twiddle is W = W_{2^L}^e = cos θ − j·sin θ, with θ = 2πe/2^L.
- ROM:
  - Depth 3·2^(L−2). Entry e holds c = round(cos θ·(2^(TWW−1)−1)) and s = round(sin θ·(2^(TWW−1)−1)).
  - Synchronous read, no reset on the array.
- Products:
  - re = x_re·c + x_im·s; im = x_im·c − x_re·s.
  - Each product is full precision, DW+TWW bits. Sums are DW+TWW+1 bits.
- Scaling:
  - Add 2^(TWW−2) (round half up), then arithmetic shift right by TWW−1.
  - Saturate to [−2^(DW−1), 2^(DW−1)−1]. No wrap is permitted.
- Trivial twiddle: when e = 0 the sample bypasses the multiplier (z = x exactly), through a delay line of the same length so alignment is unchanged.
- Datapath registers advance every cycle regardless of `valid_i`. `valid_i` only travels alongside the data and becomes `valid_o`. `cnt_o` is a pure 4-cycle delay of `cnt_i` (wraps naturally, e.g. 1023 → 0).
- Pipeline (P1–P4):
  - P1: register e, x, valid, cnt, and the bypass flag (e==0).
  - P2: ROM read of c/s; delay x, valid, cnt, bypass.
  - P3: register the four products.
  - P4: add/sub, round, saturate or bypass select; drive the outputs.

## Timing
- Latency: a sample presented at edge t appears on `z_*_o`/`valid_o`/`cnt_o` after edge t+4.
- Throughput: 1 sample per clock, no stalls, no backpressure.
- Reset:
  - All pipeline registers clear asynchronously, so `z_re_o` = `z_im_o` = 0, `cnt_o` = 0, `valid_o` = 0.
  - Mid-stream reset discards in-flight samples. No stale `valid_o` may appear after release.
  - The first valid output occurs exactly 4 cycles after the first post-release `valid_i`.
- Boundaries:
  - Counter wrap: e recomputes from the wrapped k with no glitch.
  - Back-to-back frames: no bubble.
  - `valid_i` gaps: reproduced exactly on `valid_o`, 4 cycles later.
  - Simultaneous reset release and `valid_i`: the sample on the release edge is accepted only if `rst_n_i` is high at that edge.

## Test plan
- Setup for scenarios 1–3: FFT_N=16, NLOG2=4, STAGE=0, DW=24, TWW=25.
- 1. Passthrough: cnt_i=0..3 (e=0), x=(123,−456) → z=(123,−456) bit-exact, 4 cycles later.
- 2. Quarter turn: cnt_i=6 (r=2, b0=1, b1=0, e=4, W=−j), x=(1000,0) → z=(0,−1000).
- 3. Saturation: cnt_i=5 (e=2, W=e^{−jπ/4}), x=(2^23−1, 2^23−1) → z_re=2^23−1 (saturated), z_im=0 ±1.
- 4. Full frame at N=1024: random x over 3 frames, compared against a floating-point reference model (error ≤ 1 LSB per component); cnt_o wraps 1023→0 in step with the data.
- 5. Valid gaps: valid_i pattern 1101_0011 → identical pattern on valid_o, 4 cycles later; data aligned.
- 6. Reset mid-stream: assert rst_n_i=0 for 2 cycles during a frame → all outputs 0 immediately; after release with valid_i=1, valid_o stays low 4 cycles, then its first value is correct.
